// File: rtl/led_ctrl_pkg.sv
// Shared definitions for the LED PWM controllers.
//   pwm_max(w)  : full-scale brightness for a w-bit level, also the period length
//   *_DEF       : default channel count and widths
package led_ctrl_pkg;

    localparam int N_CH_DEF  = 3;
    localparam int PWM_W_DEF = 15;
    localparam int DIV_W_DEF = 8;

    function automatic int pwm_max(input int w);
        return (1 << w) - 1;
    endfunction

endpackage

// File: rtl/fade_channel.sv
// One PWM channel: shadow target, faded level register and registered pin.
//   clk, rst_n    : system clock, async active-low reset
//   enable        : 0 forces the pin low
//   boundary      : last cycle of the shared period; target is sampled here
//   tick          : fade tick (always coincides with a boundary)
//   target, step  : live config inputs, only looked at on boundary/tick
//   cnt           : shared period counter
//   level         : current applied brightness
//   pwm           : registered PWM output bit
//   differs_nxt   : level and shadow target will differ after this edge
module fade_channel
    import led_ctrl_pkg::*;
#(
    parameter int PWM_W = PWM_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             boundary,
    input  logic             tick,
    input  logic [PWM_W-1:0] target,
    input  logic [PWM_W-1:0] step,
    input  logic [PWM_W-1:0] cnt,
    output logic [PWM_W-1:0] level,
    output logic             pwm,
    output logic             differs_nxt
);

    logic [PWM_W-1:0] shadow;
    logic [PWM_W-1:0] shadow_nxt;
    logic [PWM_W-1:0] level_nxt;
    logic [PWM_W:0]   sum;
    logic [PWM_W:0]   diff;

    // The step used on a tick is the value present at that boundary, which is
    // exactly the value the shadow would capture, so no step register is kept.
    always_comb begin
        sum        = {1'b0, level} + {1'b0, step};
        diff       = {1'b0, level} - {1'b0, step};
        shadow_nxt = boundary ? target : shadow;
        level_nxt  = level;
        if (tick) begin
            if (step == '0) begin
                level_nxt = target;
            end else if (level < target) begin
                level_nxt = (sum > {1'b0, target}) ? target : sum[PWM_W-1:0];
            end else if (level > target) begin
                // diff[PWM_W] set means the subtraction went below zero
                level_nxt = (diff[PWM_W] || (diff[PWM_W-1:0] < target))
                            ? target : diff[PWM_W-1:0];
            end
        end
        differs_nxt = (level_nxt != shadow_nxt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
            level  <= '0;
            pwm    <= 1'b0;
        end else begin
            shadow <= shadow_nxt;
            level  <= level_nxt;
            pwm    <= enable && (level > cnt);
        end
    end

endmodule

// File: rtl/pwm_fade_ctrl.sv
// N-channel PWM LED driver with boundary-synchronous target updates and
// linear fading. One shared period counter keeps all channels phase-aligned.
//   clk, rst_n  : system clock, async active-low reset
//   enable      : 0 holds counter/divider at 0, outputs low, levels frozen
//   target      : per-channel target, ch k at [k*PWM_W +: PWM_W]
//   step        : fade increment per tick, 0 snaps to target
//   fade_div    : fade tick every fade_div+1 periods
//   pwm_out     : PWM pins, ch k on bit k
//   level       : applied brightness per channel
//   period_stb  : one-cycle pulse following the last cycle of each period
//   busy        : some level still differs from its sampled target
module pwm_fade_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int N_CH  = N_CH_DEF,
    parameter int PWM_W = PWM_W_DEF,
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [N_CH*PWM_W-1:0] target,
    input  logic [PWM_W-1:0]      step,
    input  logic [DIV_W-1:0]      fade_div,
    output logic [N_CH-1:0]       pwm_out,
    output logic [N_CH*PWM_W-1:0] level,
    output logic                  period_stb,
    output logic                  busy
);

    localparam logic [PWM_W-1:0] CNT_LAST = PWM_W'(pwm_max(PWM_W) - 1);

    logic [PWM_W-1:0] cnt;
    logic [DIV_W-1:0] div;
    logic             boundary;
    logic             tick;
    logic [N_CH-1:0]  differs_nxt;

    assign boundary = enable && (cnt == CNT_LAST);
    // ">=" so that shrinking fade_div below the running div still ticks
    assign tick     = boundary && (div >= fade_div);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            div        <= '0;
            period_stb <= 1'b0;
            busy       <= 1'b0;
        end else begin
            period_stb <= boundary;
            busy       <= |differs_nxt;
            if (!enable) begin
                cnt <= '0;
                div <= '0;
            end else begin
                cnt <= boundary ? '0 : cnt + 1'b1;
                if (tick) begin
                    div <= '0;
                end else if (boundary) begin
                    div <= div + 1'b1;
                end
            end
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        fade_channel #(
            .PWM_W (PWM_W)
        ) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .enable      (enable),
            .boundary    (boundary),
            .tick        (tick),
            .target      (target[k*PWM_W +: PWM_W]),
            .step        (step),
            .cnt         (cnt),
            .level       (level[k*PWM_W +: PWM_W]),
            .pwm         (pwm_out[k]),
            .differs_nxt (differs_nxt[k])
        );
    end

endmodule
